// File: rtl/uart_reg_master.sv
// uart_reg_master: serialises register read/write requests into UART command frames.
// Latency: first tx strobe 1 cycle after acceptance; rsp_valid_o 1 cycle after the last tx/rx done.
// Backpressure: req_ready_o is high only in IDLE; optional read timeout via UART_REG_MASTER_TIMEOUT_EN.
module uart_reg_master #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
  parameter logic [7:0]  CMD_WR         = 8'h57,
  parameter logic [7:0]  CMD_RD         = 8'h52
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_we_i,
  input  logic [7:0] req_addr_i,
  input  logic [7:0] req_wdata_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_rdata_o,
  output logic       rsp_err_o,
  output logic [7:0] tx_data_o,
  output logic       tx_wr_o,
  input  logic       tx_done_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_done_i
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SEND_CMD,
    S_WAIT_CMD,
    S_SEND_ADDR,
    S_WAIT_ADDR,
    S_SEND_DATA,
    S_WAIT_DATA,
    S_WAIT_RESP,
    S_RESP
  } state_e;

  state_e     state_q, state_d;
  logic       we_q, we_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [7:0] rdata_q, rdata_d;

  logic       accept;
  logic       rx_hit;
  logic       timeout_hit;

  assign accept = req_valid_i & req_ready_o;
  // Received bytes only count while a read response is awaited; echoes elsewhere are dropped.
  assign rx_hit = (state_q == S_WAIT_RESP) & rx_done_i;

`ifdef UART_REG_MASTER_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  // Counter sits at zero outside WAIT_RESP, so it starts from zero on entry.
  always_comb begin
    cnt_d = 16'd0;
    if (state_q == S_WAIT_RESP) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  assign timeout_hit = (state_q == S_WAIT_RESP) && (cnt_q == TIMEOUT_CYCLES - 16'd1) && !rx_done_i;

  // Error flag: cleared on a new request or a real response, set on expiry.
  always_comb begin
    err_d = err_q;
    if (accept || rx_hit) begin
      err_d = 1'b0;
    end else if (timeout_hit) begin
      err_d = 1'b1;
    end
  end

  // Timeout counter and error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign rsp_err_o = err_q;
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign rsp_err_o      = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      tx_data_q <= 8'h00;
      rdata_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tx_data_q <= tx_data_d;
      rdata_q   <= rdata_d;
    end
  end

  // Next-state logic: one cycle per SEND, wait for the transceiver in each WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (accept) state_d = S_SEND_CMD;
      S_SEND_CMD:  state_d = S_WAIT_CMD;
      S_WAIT_CMD:  if (tx_done_i) state_d = S_SEND_ADDR;
      S_SEND_ADDR: state_d = S_WAIT_ADDR;
      S_WAIT_ADDR: if (tx_done_i) state_d = we_q ? S_SEND_DATA : S_WAIT_RESP;
      S_SEND_DATA: state_d = S_WAIT_DATA;
      S_WAIT_DATA: if (tx_done_i) state_d = S_RESP;
      S_WAIT_RESP: if (rx_hit || timeout_hit) state_d = S_RESP;
      S_RESP:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Moore outputs; tx_data_o keeps the last sent byte between strobes.
  always_comb begin
    req_ready_o = 1'b0;
    tx_wr_o     = 1'b0;
    tx_data_o   = tx_data_q;
    rsp_valid_o = 1'b0;
    case (state_q)
      S_IDLE:      req_ready_o = 1'b1;
      S_SEND_CMD: begin
        tx_wr_o   = 1'b1;
        tx_data_o = we_q ? CMD_WR : CMD_RD;
      end
      S_SEND_ADDR: begin
        tx_wr_o   = 1'b1;
        tx_data_o = addr_q;
      end
      S_SEND_DATA: begin
        tx_wr_o   = 1'b1;
        tx_data_o = wdata_q;
      end
      S_RESP:      rsp_valid_o = 1'b1;
      default:     ;
    endcase
  end

  // Request capture, tx byte hold and response data update.
  always_comb begin
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tx_data_d = tx_data_o;
    rdata_d   = rdata_q;
    if (accept) begin
      we_d    = req_we_i;
      addr_d  = req_addr_i;
      wdata_d = req_wdata_i;
    end
    if (rx_hit) begin
      rdata_d = rx_data_i;
    end else if (timeout_hit) begin
      rdata_d = 8'h00;
    end
  end

  assign rsp_rdata_o = rdata_q;

endmodule

// File: tb/tb_uart_reg_master.sv
// Bench for uart_reg_master: table of transactions plus hand-written corner sequences.
// A transceiver model answers each strobe with tx_done three cycles later.
// Expected bytes/responses are queued at request time and checked as the DUT emits them.
module tb_uart_reg_master;

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid_i, req_ready_o, req_we_i;
  logic [7:0] req_addr_i, req_wdata_i;
  logic       rsp_valid_o, rsp_err_o;
  logic [7:0] rsp_rdata_o;
  logic [7:0] tx_data_o;
  logic       tx_wr_o, tx_done_i;
  logic [7:0] rx_data_i;
  logic       rx_done_i;

  uart_reg_master #(
    .TIMEOUT_CYCLES(16'd100),
    .CMD_WR(CMD_WR),
    .CMD_RD(CMD_RD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_we_i(req_we_i),
    .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o),
    .tx_data_o(tx_data_o),
    .tx_wr_o(tx_wr_o),
    .tx_done_i(tx_done_i),
    .rx_data_i(rx_data_i),
    .rx_done_i(rx_done_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rx;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  vec_t       vecs[6];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  logic [7:0] tx_q[$];
  logic [8:0] rsp_q[$];
  int         trig = -10;
  int         last_rsp_cyc = -1;
  int         last_done_cyc = -1;
  int         n_done = 0;
  int         n_strobe = 0;
  bit         rx_legit = 1'b0;
  bit         chk_rsp_timing = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transceiver model: each strobe completes on the line three cycles later.
  initial begin
    int cnt;
    cnt = 0;
    tx_done_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_done_i = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          tx_done_i = 1'b1;
          n_done++;
        end
      end
      if (tx_wr_o) cnt = 3;
    end
  end

  // Monitor: compares strobes and responses against the scoreboard, checks 1-cycle latencies.
  initial begin
    logic [7:0] b;
    logic [8:0] r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (tx_wr_o) begin
          n_strobe++;
          if (tx_q.size() == 0) begin
            chk("strobe_expected", 32'(tx_q.size()), 32'd1);
          end else begin
            b = tx_q.pop_front();
            chk("tx_byte", 32'(tx_data_o), 32'(b));
            chk("strobe_latency", 32'(cyc - trig), 32'd1);
          end
        end
        if (rsp_valid_o) begin
          last_rsp_cyc = cyc;
          if (rsp_q.size() == 0) begin
            chk("rsp_expected", 32'(rsp_q.size()), 32'd1);
          end else begin
            r = rsp_q.pop_front();
            chk("rsp_rdata", 32'(rsp_rdata_o), 32'(r[7:0]));
            chk("rsp_err", 32'(rsp_err_o), 32'(r[8]));
            if (chk_rsp_timing) chk("rsp_latency", 32'(cyc - trig), 32'd1);
          end
        end
        if (req_valid_i && req_ready_o) trig = cyc;
        if (tx_done_i) begin
          trig = cyc;
          last_done_cyc = cyc;
        end
        if (rx_done_i && rx_legit) trig = cyc;
      end
    end
  end

  task automatic push_exp(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                          input logic [7:0] exp_rdata, input logic exp_err);
    tx_q.push_back(we ? CMD_WR : CMD_RD);
    tx_q.push_back(addr);
    if (we) tx_q.push_back(wdata);
    rsp_q.push_back({exp_err, exp_rdata});
  endtask

  task automatic wait_ready(input string nm);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (req_ready_o) break;
    end
    chk(nm, 32'(req_ready_o), 32'd1);
  endtask

  task automatic send_req(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    @(posedge clk);
    #1;
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    wait_ready("req_ready_wait");
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (n_done >= target) break;
    end
    chk("tx_done_wait", 32'(n_done >= target), 32'd1);
  endtask

  task automatic drain(input int budget, input string nm);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (rsp_q.size() == 0 && tx_q.size() == 0) break;
    end
    chk(nm, 32'(rsp_q.size() + tx_q.size()), 32'd0);
  endtask

  // Drive the far-end response byte two cycles into WAIT_RESP.
  task automatic respond(input logic [7:0] data);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rx_data_i = data;
    rx_done_i = 1'b1;
    rx_legit  = 1'b1;
    @(posedge clk);
    #1;
    rx_done_i = 1'b0;
    rx_legit  = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    int base;
    base = n_done;
    push_exp(v.we, v.addr, v.wdata, v.exp_rdata, v.exp_err);
    send_req(v.we, v.addr, v.wdata);
    if (!v.we) begin
      wait_done(base + 2);
      respond(v.rx);
    end
    drain(300, "txn_drain");
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_tx_wr"},     32'(tx_wr_o),     32'd0);
    chk({pfx, "_tx_data"},   32'(tx_data_o),   32'h00);
    chk({pfx, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
    chk({pfx, "_rsp_rdata"}, 32'(rsp_rdata_o), 32'h00);
    chk({pfx, "_rsp_err"},   32'(rsp_err_o),   32'd0);
    chk({pfx, "_req_ready"}, 32'(req_ready_o), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    int base;
    int strobes0;
    int rdy_cyc;

    //          we    addr   wdata  rx     rdata  err
    vecs[0] = '{1'b1, 8'h03, 8'hA5, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 8'h03, 8'h00, 8'hA5, 8'hA5, 1'b0};
    vecs[2] = '{1'b1, 8'hFF, 8'h00, 8'h00, 8'hA5, 1'b0};
    vecs[3] = '{1'b0, 8'h80, 8'h11, 8'h3C, 8'h3C, 1'b0};
    vecs[4] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'h3C, 1'b0};
    vecs[5] = '{1'b0, 8'h7F, 8'h00, 8'h00, 8'h00, 1'b0};

    rst = 1'b1;
    req_valid_i = 1'b0;
    req_we_i = 1'b0;
    req_addr_i = 8'h00;
    req_wdata_i = 8'h00;
    rx_data_i = 8'h00;
    rx_done_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("reset");

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i]);
    end

    // Stray RX byte during WAIT_ADDR of a read must be ignored.
    base = n_done;
    push_exp(1'b0, 8'h44, 8'h00, 8'h3C, 1'b0);
    send_req(1'b0, 8'h44, 8'h00);
    wait_done(base + 1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rx_data_i = 8'hFF;
    rx_done_i = 1'b1;
    @(posedge clk);
    #1;
    rx_done_i = 1'b0;
    wait_done(base + 2);
    respond(8'h3C);
    drain(300, "stray_drain");

`ifdef UART_REG_MASTER_TIMEOUT_EN
    // Read with no response: aborted 100 cycles after entering WAIT_RESP.
    chk_rsp_timing = 1'b0;
    push_exp(1'b0, 8'h0F, 8'h00, 8'h00, 1'b1);
    send_req(1'b0, 8'h0F, 8'h00);
    drain(500, "timeout_drain");
    chk("timeout_latency", 32'(last_rsp_cyc - last_done_cyc), 32'd101);
    @(negedge clk);
    chk("timeout_ready", 32'(req_ready_o), 32'd1);
    chk_rsp_timing = 1'b1;
`endif

    // Reset during WAIT_ADDR of a write: frame abandoned, no response.
    base = n_done;
    push_exp(1'b1, 8'h10, 8'h77, 8'h00, 1'b0);
    send_req(1'b1, 8'h10, 8'h77);
    wait_done(base + 1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    tx_q.delete();
    rsp_q.delete();
    strobes0 = n_strobe;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("midrst");
    repeat (12) @(negedge clk);
    chk("midrst_no_strobe", 32'(n_strobe - strobes0), 32'd0);
    run_txn('{1'b1, 8'h20, 8'h99, 8'h00, 8'h00, 1'b0});

    // Back-to-back writes with req_valid_i held high.
    strobes0 = n_strobe;
    push_exp(1'b1, 8'h21, 8'h5A, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_addr_i  = 8'h21;
    req_wdata_i = 8'h5A;
    wait_ready("b2b_first_ready");
    @(posedge clk);
    #1;
    req_addr_i  = 8'h22;
    req_wdata_i = 8'hC3;
    push_exp(1'b1, 8'h22, 8'hC3, 8'h00, 1'b0);
    wait_ready("b2b_second_ready");
    rdy_cyc = cyc;
    chk("b2b_accept_gap", 32'(rdy_cyc - last_rsp_cyc), 32'd1);
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    drain(300, "b2b_drain");
    chk("b2b_strobes", 32'(n_strobe - strobes0), 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_reg_master.md
# uart_reg_master

Host-side initiator for the UART register-access protocol served by the on-chip register FSM. It accepts register read/write requests on a valid/ready port and serialises each one into command, address and data bytes through a byte-level UART transceiver. For reads it waits for the single response byte and returns it on a response port. It is used in a controller FPGA that drives the waveform generator, and as the protocol driver in system benches.

## Interface
- `TIMEOUT_CYCLES`, default 16'd50000: `clk` cycles spent in WAIT_RESP before a read is aborted (only with the timeout feature).
- `CMD_WR`, default 8'h57: command byte for a write frame.
- `CMD_RD`, default 8'h52: command byte for a read frame.
- `clk` input 1: single system clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid_i` input 1: request present.
- `req_ready_o` output 1: block is idle and accepts a request.
- `req_we_i` input 1: 1 = write, 0 = read.
- `req_addr_i` input 8: register address.
- `req_wdata_i` input 8: write data, ignored for reads.
- `rsp_valid_o` output 1: one-cycle pulse marking completion of a transaction.
- `rsp_rdata_o` output 8: read data, held until the next response.
- `rsp_err_o` output 1: read timed out; valid while `rsp_valid_o` is high.
- `tx_data_o` output 8: byte to the transceiver.
- `tx_wr_o` output 1: one-cycle strobe that starts transmission of `tx_data_o`.
- `tx_done_i` input 1: one-cycle pulse when a byte has left the line.
- `rx_data_i` input 8: received byte.
- `rx_done_i` input 1: one-cycle pulse when `rx_data_i` is valid.

## Operation
- Frame formats:
  - Write frame: `CMD_WR`, addr, data.
  - Read frame: `CMD_RD`, addr, then one response byte from the far end.
- States: IDLE, SEND_CMD, WAIT_CMD, SEND_ADDR, WAIT_ADDR, SEND_DATA, WAIT_DATA, WAIT_RESP, RESP.
- IDLE:
  - `req_ready_o` = 1 in this state only.
  - On `req_valid_i & req_ready_o`, capture we/addr/wdata and go to SEND_CMD.
- Each SEND_x state lasts exactly one cycle:
  - `tx_wr_o` = 1 and `tx_data_o` = the byte; then go to the matching WAIT_x.
- Each WAIT_x state holds until `tx_done_i`:
  - WAIT_CMD goes to SEND_ADDR.
  - WAIT_ADDR goes to SEND_DATA (write) or WAIT_RESP (read).
  - WAIT_DATA goes to RESP.
- WAIT_RESP:
  - On `rx_done_i`, latch `rx_data_i` into `rsp_rdata_o`, clear error, go to RESP.
- RESP lasts one cycle:
  - `rsp_valid_o` = 1, then go to IDLE.
  - For writes, `rsp_rdata_o` is unchanged and `rsp_err_o` = 0.
- Ignored inputs:
  - `rx_done_i` in any state other than WAIT_RESP (stray or echo bytes).
  - `tx_done_i` outside the WAIT_x states.
- `tx_data_o` holds its last driven byte between strobes.

## Timing
- Reset values:
  - `tx_wr_o` = 0, `tx_data_o` = 8'h00.
  - `rsp_valid_o` = 0, `rsp_rdata_o` = 8'h00, `rsp_err_o` = 0.
  - state = IDLE, so `req_ready_o` = 1 in the first cycle after `rst` falls.
- Acceptance to first `tx_wr_o`: 1 cycle. Request is accepted at edge N; the strobe is high during cycle N+1.
- `tx_done_i` at edge M: the next strobe is in cycle M+1. There is no back-to-back gap beyond that.
- Write: `rsp_valid_o` is high in the cycle after the `tx_done_i` of the data byte.
- Read: `rsp_valid_o` is high in the cycle after `rx_done_i`; `rsp_rdata_o` is valid in that same cycle.
- `tx_done_i` arriving in the same cycle as the strobe cannot occur; behaviour in that case is unspecified.
- `rx_done_i` and timeout expiry in the same cycle: the received byte wins and `rsp_err_o` = 0.
- Reset mid-frame:
  - Next state is IDLE and no `rsp_valid_o` is generated.
  - A byte already handed to the transceiver may still complete on the line; the far end recovers through its own framing.
- Back-to-back requests: `req_ready_o` returns to 1 in the cycle after RESP.
- Minimum transaction length is therefore 3 (write) or 2 (read) UART byte times plus 2 cycles.

## Configuration
- Macro: `UART_REG_MASTER_TIMEOUT_EN`.
- When defined:
  - A 16-bit counter clears on entry to WAIT_RESP and increments every cycle in that state.
  - When it reaches `TIMEOUT_CYCLES - 1` without `rx_done_i`, go to RESP with `rsp_err_o` = 1 and `rsp_rdata_o` = 8'h00.
- When not defined:
  - No counter is built and WAIT_RESP waits indefinitely.
  - `rsp_err_o` is tied to 0.

## Test plan
- Write: req we=1, addr=8'h03, wdata=8'hA5 → `tx_wr_o` pulses with 8'h57, 8'h03, 8'hA5, each one cycle after the previous `tx_done_i`. `rsp_valid_o` one cycle after the third `tx_done_i`; `rsp_err_o` = 0.
- Read: req we=0, addr=8'h03; bench returns `rx_data_i` = 8'hA5 → bytes 8'h52, 8'h03 only. Then `rsp_valid_o` = 1, `rsp_rdata_o` = 8'hA5 in the cycle after `rx_done_i`.
- Stray RX: `rx_done_i` with 8'hFF during WAIT_ADDR of a read, then 8'h3C in WAIT_RESP → `rsp_rdata_o` = 8'h3C.
- Timeout (macro on, `TIMEOUT_CYCLES` = 100): read with no response → `rsp_valid_o` exactly 100 cycles after entering WAIT_RESP, with `rsp_err_o` = 1 and `rsp_rdata_o` = 8'h00. Then `req_ready_o` = 1.
- Reset mid-frame: assert `rst` for 1 cycle while in WAIT_ADDR of a write → no further `tx_wr_o`, no `rsp_valid_o`, all outputs at reset values. A new write then produces a full 3-byte frame.
- Back-to-back: `req_valid_i` held high with two writes → the second is accepted the cycle after the first `rsp_valid_o`, and 6 strobes are issued in order.
